dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dataMem) between two requesters: port 0 = processor
//  load/store path, port 1 = program loader / debug port. Round-robin arbitration with an
//  optional bounded burst lock. Synchronous-read forwarding: read data returns one cycle
//  after grant. Sits between Processor's ALUresult/WriteData/mem_write nets and dataMem.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width
//  MAX_BURST  4   max consecutive locked grants before forced hand-over (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  m0_req     in   1   port 0 access request (held until m0_gnt)
//  m0_we      in   1   port 0 write enable (0 = read)
//  m0_lock    in   1   port 0 requests to keep ownership for following beats
//  m0_addr    in   AW  port 0 byte address
//  m0_wdata   in   DW  port 0 write data
//  m0_gnt     out  1   port 0 access accepted this cycle (low = processor stall)
//  m0_rvalid  out  1   port 0 read data valid (cycle after a read grant)
//  m0_rdata   out  DW  port 0 read data
//  m1_*       -    -   identical set for port 1
//  mem_we     out  1   to dataMem WE
//  mem_addr   out  AW  to dataMem A
//  mem_wd     out  DW  to dataMem Wd
//  mem_rd     in   DW  from dataMem Rd, valid one cycle after address issued
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0 (port 0 favoured), beat_cnt=0, m*_rvalid=0, m*_rdata=0,
//    rd_owner cleared. gnt/mem_* are combinational: with all req low, gnt=0, mem_we=0,
//    mem_addr=mem_wd=0. Reset mid-access drops any pending rvalid; no partial writes issued.
//  - At most one gnt per cycle. gnt is combinational from req and state; granted port's
//    addr/wdata/we drive mem_* the same cycle. mem_we = granted && we only.
//  - Read grant in cycle N -> mx_rvalid=1, mx_rdata=mem_rd in cycle N+1 (registered
//    owner tag). Write grant produces no rvalid. Back-to-back grants every cycle allowed.
//  - FSM {IDLE, LOCK0, LOCK1}:
//    IDLE: one req -> grant it. Both -> grant port rr_ptr. After grant to k: rr_ptr<=~k;
//      if mk_lock -> LOCKk, beat_cnt<=1; else stay IDLE.
//    LOCKk: mk_req && mk_lock && (beat_cnt<MAX_BURST || other port idle) -> grant k,
//      beat_cnt<=sat(beat_cnt+1), stay. Otherwise release same cycle: re-arbitrate as IDLE
//      with k lowest priority (grant other if requesting, no bubble); next state per IDLE rules.
//    Dropping lock with req still high = final locked beat granted, then IDLE.
//  - Forced hand-over: beat_cnt==MAX_BURST with other port requesting -> other port wins;
//    holder must re-request. beat_cnt saturates at MAX_BURST, clears on leaving LOCKk.
//  - No address range checks; addresses pass through unmodified.
// STRUCTURE
//  - Shared include arb_defs.vh: FSM state encodings (ARB_IDLE/ARB_LOCK0/ARB_LOCK1),
//    port index constants.
//  - One sub-module: rr_pick2 (combinational 2-way round-robin pick: req[1:0], ptr -> gnt[1:0]).
//  - Top: FSM + beat counter, mem mux, read-return owner register.
// TESTING
//  1 Reset: rst=1 two cycles with both req high -> gnt=0, rvalid=0, rdata=0; first
//    post-reset cycle both req -> m0_gnt=1.
//  2 Read return: m0 read addr 0x10, mem holds 0xDEADBEEF -> m0_gnt cycle N, m0_rvalid=1,
//    m0_rdata=0xDEADBEEF at N+1; m1_rvalid stays 0.
//  3 Round-robin: both req continuous, no lock -> gnt alternates 0,1,0,1 every cycle.
//  4 Burst limit: m1 lock+req, m0 req, MAX_BURST=4 -> m1 granted 4 consecutive cycles,
//    then m0 granted in cycle 5 with no idle cycle.
//  5 Lock alone: m0 lock+req 10 cycles, m1 idle -> m0 granted all 10 (beat_cnt saturates).
//  6 Reset mid-read: m1 read granted cycle N, rst=1 at N+1 -> m1_rvalid=0 at N+1, N+2;
//    state IDLE after reset.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter:
// FSM state encodings and requester port indices.
package dmem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_LOCK0 = 2'd1;
  localparam logic [1:0] ARB_LOCK1 = 2'd2;

  localparam int P0 = 0;
  localparam int P1 = 1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright,
// a tie goes to the port named by ptr.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter with bounded burst lock
// and one-cycle read-return forwarding to the owning port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BONE = BW'(1);

  logic [1:0]    state, state_nx;
  logic          rr_ptr, rr_nx;
  logic [BW-1:0] beat, beat_nx;
  logic [1:0]    rv_q;

  logic [1:0] req, lock, pick, gnt;
  logic       pick_ptr, hold, hold_k;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};

  rr_pick2 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (pick)
  );

  // On release the holder drops to lowest priority, so the
  // other port takes over the same cycle with no bubble.
  always_comb begin
    hold     = 1'b0;
    hold_k   = 1'b0;
    pick_ptr = rr_ptr;
    unique case (state)
      ARB_LOCK0: begin
        hold_k   = 1'b0;
        pick_ptr = 1'b1;
        hold     = req[P0] && lock[P0] &&
                   (beat < BMAX || !req[P1]);
      end
      ARB_LOCK1: begin
        hold_k   = 1'b1;
        pick_ptr = 1'b0;
        hold     = req[P1] && lock[P1] &&
                   (beat < BMAX || !req[P0]);
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (hold) gnt = hold_k ? 2'b10 : 2'b01;
      else      gnt = pick;
    end
  end

  always_comb begin
    state_nx = ARB_IDLE;
    beat_nx  = '0;
    rr_nx    = rr_ptr;
    if (hold) begin
      state_nx = state;
      beat_nx  = (beat == BMAX) ? beat : beat + BONE;
      rr_nx    = ~hold_k;
    end else if (gnt[P1]) begin
      rr_nx = 1'b0;
      if (lock[P1]) begin
        state_nx = ARB_LOCK1;
        beat_nx  = BONE;
      end
    end else if (gnt[P0]) begin
      rr_nx = 1'b1;
      if (lock[P0]) begin
        state_nx = ARB_LOCK0;
        beat_nx  = BONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      rr_ptr <= 1'b0;
      beat   <= '0;
      rv_q   <= 2'b00;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
      beat   <= beat_nx;
      rv_q   <= {gnt[P1] & ~m1_we, gnt[P0] & ~m0_we};
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    unique case (1'b1)
      gnt[P1]: begin
        mem_we   = m1_we;
        mem_addr = m1_addr;
        mem_wd   = m1_wdata;
      end
      gnt[P0]: begin
        mem_we   = m0_we;
        mem_addr = m0_addr;
        mem_wd   = m0_wdata;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = gnt[P0];
  assign m1_gnt    = gnt[P1];
  // Reset held mid-access suppresses a pending return at once.
  assign m0_rvalid = rv_q[P0] & ~rst;
  assign m1_rvalid = rv_q[P1] & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_rd : '0;
  assign m1_rdata  = m1_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a
// small synchronous-read memory model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
    mem_rd <= mem[mem_addr[9:2]];
  end

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0;
    m0_addr = 0; m0_wdata = 0;
    m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; m0_req = 1; m1_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin
        n_bad++;
        $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt});
      end
      n_cmp++;
      if ({m0_rvalid, m1_rvalid, mem_we} !== 3'b000) begin
        n_bad++;
        $display("FAIL rst_valid: got %b want 000",
                 {m0_rvalid, m1_rvalid, mem_we});
      end
      n_cmp++;
      if ((m0_rdata | m1_rdata) !== 32'h0) begin
        n_bad++;
        $display("FAIL rst_rdata: got %h/%h want 0", m0_rdata, m1_rdata);
      end
    end
    @(negedge clk); rst = 0; #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL post_rst_gnt: got %b want 01", {m1_gnt, m0_gnt});
    end
    @(negedge clk); idle();
  endtask

  task automatic test_read_return();
    idle(); #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wd} !== 65'h0) begin
      n_bad++;
      $display("FAIL idle_mem: got we=%b a=%h wd=%h want 0",
               mem_we, mem_addr, mem_wd);
    end
    // m1 writes 0xDEADBEEF to 0x10
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({m1_gnt, mem_we, mem_addr, mem_wd} !== {2'b11, 32'h10, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL wr_issue: got g=%b we=%b a=%h wd=%h want 1 1 10 deadbeef",
               m1_gnt, mem_we, mem_addr, mem_wd);
    end
    // m0 reads 0x10
    @(negedge clk); idle();
    m0_req = 1; m0_addr = 32'h10; #1;
    n_cmp++;
    if ({m1_rvalid, m0_gnt, mem_we, mem_addr} !== {3'b010, 32'h10}) begin
      n_bad++;
      $display("FAIL rd_issue: got rv1=%b g0=%b we=%b a=%h want 0 1 0 10",
               m1_rvalid, m0_gnt, mem_we, mem_addr);
    end
    @(negedge clk); idle(); #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL rd_return: got rv0=%b rv1=%b d=%h want 1 0 deadbeef",
               m0_rvalid, m1_rvalid, m0_rdata);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_one_shot: got %b want 0", m0_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic e1;
    @(negedge clk); idle();
    m1_req = 1; m1_addr = 32'h200;
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h100;
    for (int i = 0; i < 6; i++) begin
      e1 = i[0];
      #1;
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== {e1, ~e1} ||
          mem_addr !== (e1 ? 32'h200 : 32'h100)) begin
        n_bad++;
        $display("FAIL rr_%0d: got g=%b a=%h want g=%b", i,
                 {m1_gnt, m0_gnt}, mem_addr, {e1, ~e1});
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_burst_limit();
    @(negedge clk); idle();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin m0_req = 1; m0_addr = 32'h44; end
      #1;
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL burst_%0d: got %b want %b", i,
                 {m1_gnt, m0_gnt}, (i < 4) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_lock_alone();
    @(negedge clk); idle();
    m0_req = 1; m0_lock = 1; m0_we = 1; m0_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      m0_wdata = 32'h1000 + i; #1;
      n_cmp++;
      if ({m1_gnt, m0_gnt, mem_we} !== 3'b011) begin
        n_bad++;
        $display("FAIL lock_%0d: got %b want 011", i,
                 {m1_gnt, m0_gnt, mem_we});
      end
      @(negedge clk);
    end
    m0_lock = 0; #1;
    n_cmp++;
    if (m0_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_final: got %b want 1", m0_gnt);
    end
    @(negedge clk);
    m0_we = 0; m1_req = 1; #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_bad++;
      $display("FAIL unlock_rr: got %b want 10", {m1_gnt, m0_gnt});
    end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); idle();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h10; #1;
    n_cmp++;
    if (m1_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_gnt: got %b want 1", m1_gnt);
    end
    @(negedge clk);
    rst = 1; m0_req = 1; #1;
    n_cmp++;
    if ({m1_rvalid, m1_gnt, m0_gnt, mem_we} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_rst: got %b want 0000",
               {m1_rvalid, m1_gnt, m0_gnt, mem_we});
    end
    @(negedge clk);
    rst = 0; #1;
    n_cmp++;
    if ({m1_rvalid, m1_gnt, m0_gnt} !== 3'b001) begin
      n_bad++;
      $display("FAIL post_mid: got rv1/g1/g0=%b want 001",
               {m1_rvalid, m1_gnt, m0_gnt});
    end
    @(negedge clk); idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_read_return();
    test_round_robin();
    test_burst_limit();
    test_lock_alone();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
